pipe_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage core (pc, if, id, ex, mem, wb).
//  - Merges stall requests from id and ex.
//  - Runs the multi-cycle divider handshake.
//  - Issues pipeline flushes with a redirect pc.
//  - Keeps a saturating stall-cycle performance counter.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/sat_counter.sv | 38 +++
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions for the pipeline sequencing controller.
//  ctrl_state_e : controller FSM states
//  STALL_*      : per-stage hold patterns (bit0 pc .. bit5 wb)
package cpu_pkg;

  typedef enum logic [1:0] {RUN, DIV_WAIT, FLUSH} ctrl_state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;  // hold pc, if, id
  localparam logic [5:0] STALL_EX   = 6'b001111;  // hold pc, if, id, ex

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//  clk   : clock, rising edge
//  rst   : synchronous reset, active-high
//  inc_i : count this cycle (ignored once at all-ones)
//  clr_i : clear to 0, takes priority over inc_i
//  cnt_o : current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Merges id/ex stall requests, runs the divider handshake with a timeout,
// issues flushes with a redirect pc and counts stalled cycles.
//  clk / rst      : clock, synchronous active-high reset
//  stallreq_id_i  : id load-use stall request
//  stallreq_ex_i  : ex single-cycle stall request
//  div_start_i    : divide launch pulse
//  div_ready_i    : divide result valid pulse
//  flush_req_i    : flush request, flush_pc_i is the redirect target
//  cnt_clr_i      : clear the stall counter
//  stall_o        : per-stage hold vector
//  flush_o        : clear all stage registers
//  new_pc_o       : redirect pc, valid with flush_o
//  div_cancel_o   : abort in-flight divide
//  div_abort_o    : divide timed out
//  stall_cnt_o    : saturating count of stalled cycles
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned InstAddrBus = 32,
  parameter int unsigned StallBus    = 6,
  parameter int unsigned FlushCycles = 2,
  parameter int unsigned DivTimeout  = 64,
  parameter int unsigned CntBus      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id_i,
  input  logic                   stallreq_ex_i,
  input  logic                   div_start_i,
  input  logic                   div_ready_i,
  input  logic                   flush_req_i,
  input  logic [InstAddrBus-1:0] flush_pc_i,
  input  logic                   cnt_clr_i,
  output logic [StallBus-1:0]    stall_o,
  output logic                   flush_o,
  output logic [InstAddrBus-1:0] new_pc_o,
  output logic                   div_cancel_o,
  output logic                   div_abort_o,
  output logic [CntBus-1:0]      stall_cnt_o
);

  localparam int unsigned TmoW     = $clog2(DivTimeout);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(DivTimeout - 1);
  localparam logic [3:0]      BubLoad = 4'(FlushCycles - 1);

  ctrl_state_e            state_q, state_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [3:0]             bub_q, bub_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    bub_d        = bub_q;
    pc_d         = pc_q;
    stall_o      = StallBus'(STALL_NONE);
    flush_o      = 1'b0;
    new_pc_o     = '0;
    div_cancel_o = 1'b0;
    div_abort_o  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (flush_req_i) begin
          flush_o  = 1'b1;
          new_pc_o = flush_pc_i;
          pc_d     = flush_pc_i;
          bub_d    = BubLoad;
          state_d  = FLUSH;
        end else if (div_start_i) begin
          stall_o = StallBus'(STALL_EX);
          tmo_d   = '0;
          state_d = DIV_WAIT;
        end else if (stallreq_ex_i) begin
          stall_o = StallBus'(STALL_EX);
        end else if (stallreq_id_i) begin
          stall_o = StallBus'(STALL_ID);
        end
      end

      DIV_WAIT: begin
        if (flush_req_i) begin
          // Flush beats a same-cycle ready; the divide result is dropped.
          div_cancel_o = 1'b1;
          flush_o      = 1'b1;
          new_pc_o     = flush_pc_i;
          pc_d         = flush_pc_i;
          bub_d        = BubLoad;
          state_d      = FLUSH;
        end else if (div_ready_i) begin
          state_d = RUN;
        end else if (tmo_q == TmoLast) begin
          div_abort_o  = 1'b1;
          div_cancel_o = 1'b1;
          state_d      = RUN;
        end else begin
          stall_o = StallBus'(STALL_EX);
          tmo_d   = tmo_q + TmoW'(1);
        end
      end

      FLUSH: begin
        flush_o = 1'b1;
        if (flush_req_i) begin
          new_pc_o = flush_pc_i;
          pc_d     = flush_pc_i;
          bub_d    = BubLoad;
        end else begin
          new_pc_o = pc_q;
          if (bub_q == 4'd0) begin
            state_d = RUN;
          end else begin
            bub_d = bub_q - 4'd1;
          end
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tmo_q   <= '0;
      bub_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      bub_q   <= bub_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(
    .Width(CntBus)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(|stall_o),
    .clr_i(cnt_clr_i),
    .cnt_o(stall_cnt_o)
  );

endmodule
